// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the data memory controller
package mem_pkg;

  typedef enum logic [2:0] {
    AM_LB  = 3'b000,
    AM_LH  = 3'b001,
    AM_LW  = 3'b010,
    AM_LBU = 3'b011,
    AM_LHU = 3'b100,
    AM_SB  = 3'b101,
    AM_SH  = 3'b110,
    AM_SW  = 3'b111
  } addr_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    DMA_RD,
    DMA_WR,
    DMA_FIN
  } ctrl_state_t;

  // A load is the only safe value to leave on the port between accesses.
  localparam addr_mode_t IDLE_MODE = AM_LW;

  function automatic logic is_store(input addr_mode_t m);
    return m >= AM_SB;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-way round-robin arbiter, bit 0 = cpu, bit 1 = dma
module dmem_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // 1 = dma held the last grant; resets to dma so the cpu wins the first tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (en && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - shares one data memory port between cpu accesses and dma word bursts
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_MAX  = 16,
  parameter int LEN_W      = $clog2(BURST_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [2:0]            cpu_addr_mode,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic                  dma_write,
  input  logic [ADDR_WIDTH-1:0] dma_base,
  input  logic [LEN_W-1:0]      dma_len,
  input  logic                  dma_beat_valid,
  output logic                  dma_beat_ready,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_rsp_valid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_done,
  output logic [2:0]            mem_addr_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  ctrl_state_t           state;
  addr_mode_t            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;

  logic [1:0]            grant;
  logic                  idle_ok;
  logic                  cpu_fire;
  logic                  dma_fire;
  logic [LEN_W-1:0]      len_sat;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  last_beat;
  addr_mode_t            mode_d;

  assign idle_ok       = (state == IDLE) && rst_n;
  assign cpu_req_ready = idle_ok && !grant[1];
  assign dma_req_ready = idle_ok && !grant[0];
  assign cpu_fire      = cpu_req_valid && cpu_req_ready;
  assign dma_fire      = dma_req_valid && dma_req_ready;

  assign len_sat   = (dma_len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : dma_len;
  assign beat_addr = base_q + ADDR_WIDTH'({cnt_q, 2'b00});
  assign last_beat = (cnt_q == len_q - LEN_W'(1));

  assign dma_beat_ready = (state == DMA_WR) && rst_n;

  dmem_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({dma_req_valid, cpu_req_valid}),
    .en    (idle_ok),
    .grant (grant)
  );

  // The port is gated by rst_n so a reset cycle can never carry a store.
  always_comb begin
    mode_d    = IDLE_MODE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state)
        CPU_ACC: begin
          mode_d    = mode_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        DMA_RD: begin
          mode_d   = AM_LW;
          mem_addr = beat_addr;
        end
        DMA_WR: begin
          if (dma_beat_valid) begin
            mode_d    = AM_SW;
            mem_addr  = beat_addr;
            mem_wdata = dma_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_mode = mode_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= IDLE_MODE;
      addr_q        <= '0;
      wdata_q       <= '0;
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rdata     <= '0;
      dma_rsp_valid <= 1'b0;
      dma_rdata     <= '0;
      dma_done      <= 1'b0;
    end else begin
      cpu_rsp_valid <= 1'b0;
      dma_rsp_valid <= 1'b0;
      dma_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_fire) begin
            mode_q  <= addr_mode_t'(cpu_addr_mode);
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            state   <= CPU_ACC;
          end else if (dma_fire) begin
            base_q <= {dma_base[ADDR_WIDTH-1:2], 2'b00};
            len_q  <= len_sat;
            cnt_q  <= '0;
            if (len_sat == '0) begin
              dma_done <= 1'b1;
              state    <= DMA_FIN;
            end else begin
              state <= dma_write ? DMA_WR : DMA_RD;
            end
          end
        end
        CPU_ACC: begin
          if (!is_store(mode_q)) cpu_rdata <= mem_rdata;
          cpu_rsp_valid <= 1'b1;
          state         <= IDLE;
        end
        DMA_RD: begin
          dma_rdata     <= mem_rdata;
          dma_rsp_valid <= 1'b1;
          cnt_q         <= cnt_q + LEN_W'(1);
          if (last_beat) begin
            dma_done <= 1'b1;
            state    <= DMA_FIN;
          end
        end
        DMA_WR: begin
          if (dma_beat_valid) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (last_beat) begin
              dma_done <= 1'b1;
              state    <= DMA_FIN;
            end
          end
        end
        DMA_FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
